// File: rtl/disp_mux2.sv
// Two-digit multiplexed 7-segment driver: TENS -> GAP0 -> UNITS -> GAP1 refresh with blank gaps.
// Optional leading-zero blanking of the tens digit via `define DISP_LZB_EN.
module disp_mux2 #(
  parameter int unsigned DIV = 4,
  parameter int unsigned GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int unsigned LEN_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int unsigned CW      = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;

  typedef enum logic [1:0] {
    ST_TENS  = 2'd0,
    ST_GAP0  = 2'd1,
    ST_UNITS = 2'd2,
    ST_GAP1  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_sh_t;
  logic [3:0]      r_sh_u;
  logic [3:0]      r_disp_t;
  logic [3:0]      r_disp_u;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_last;
  logic [3:0]      w_sh_t_nxt;
  logic [3:0]      w_sh_u_nxt;
  logic [3:0]      w_disp_t_nxt;
  logic [3:0]      w_disp_u_nxt;
  logic [6:0]      w_seg_nxt;
  logic [1:0]      w_an_nxt;
  logic            w_err_nxt;

  // BCD to segments {g,f,e,d,c,b,a}; non-BCD values show a dash
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Next state, shadow/display latching and next registered outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_cnt_last   = CW'(GAP - 1);
    w_sh_t_nxt   = r_sh_t;
    w_sh_u_nxt   = r_sh_u;
    w_disp_t_nxt = r_disp_t;
    w_disp_u_nxt = r_disp_u;
    w_seg_nxt    = 7'b0000000;
    w_an_nxt     = 2'b11;
    w_err_nxt    = 1'b0;

    if (r_state == ST_TENS || r_state == ST_UNITS) begin
      w_cnt_last = CW'(DIV - 1);
    end

    if (r_cnt == w_cnt_last) begin
      w_cnt_nxt = '0;
      case (r_state)
        ST_TENS:  w_state_nxt = ST_GAP0;
        ST_GAP0:  w_state_nxt = ST_UNITS;
        ST_UNITS: w_state_nxt = ST_GAP1;
        ST_GAP1:  w_state_nxt = ST_TENS;
        default:  w_state_nxt = ST_GAP1;
      endcase
    end

    if (ld) begin
      w_sh_t_nxt = tens;
      w_sh_u_nxt = units;
    end

    // Displayed digits sample the pre-load shadow on phase entry
    if (w_state_nxt == ST_TENS && r_state != ST_TENS) begin
      w_disp_t_nxt = r_sh_t;
    end
    if (w_state_nxt == ST_UNITS && r_state != ST_UNITS) begin
      w_disp_u_nxt = r_sh_u;
    end

    case (w_state_nxt)
      ST_TENS: begin
`ifdef DISP_LZB_EN
        if (w_disp_t_nxt != 4'd0) begin
          w_an_nxt  = 2'b10;
          w_seg_nxt = decode(w_disp_t_nxt);
        end
`else
        w_an_nxt  = 2'b10;
        w_seg_nxt = decode(w_disp_t_nxt);
`endif
      end
      ST_UNITS: begin
        w_an_nxt  = 2'b01;
        w_seg_nxt = decode(w_disp_u_nxt);
      end
      default: begin
        w_an_nxt  = 2'b11;
        w_seg_nxt = 7'b0000000;
      end
    endcase

    w_err_nxt = (w_sh_t_nxt > 4'd9) | (w_sh_u_nxt > 4'd9);
  end

  // State, shadow and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_GAP1;
      r_cnt    <= '0;
      r_sh_t   <= 4'd0;
      r_sh_u   <= 4'd0;
      r_disp_t <= 4'd0;
      r_disp_u <= 4'd0;
      seg      <= 7'b0000000;
      an       <= 2'b11;
      err      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sh_t   <= w_sh_t_nxt;
      r_sh_u   <= w_sh_u_nxt;
      r_disp_t <= w_disp_t_nxt;
      r_disp_u <= w_disp_u_nxt;
      seg      <= w_seg_nxt;
      an       <= w_an_nxt;
      err      <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_disp_mux2.sv
// Self-checking bench for disp_mux2: directed scenarios with literal expectations plus
// randomized load/reset traffic checked every cycle against a position-in-period model.
module tb_disp_mux2;

  localparam int DIV    = 4;
  localparam int GAP    = 1;
  localparam int PERIOD = 2 * (DIV + GAP);

  logic       clk;
  logic       rst;
  logic       ld;
  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int n_checks;
  int n_pass;

  disp_mux2 #(.DIV(DIV), .GAP(GAP)) dut (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .tens  (tens),
    .units (units),
    .seg   (seg),
    .an    (an),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: seven-segment table and position in the refresh period since reset
  logic [6:0] dec_tab [16];
  initial begin
    dec_tab[0] = 7'b0111111; dec_tab[1] = 7'b0000110; dec_tab[2] = 7'b1011011;
    dec_tab[3] = 7'b1001111; dec_tab[4] = 7'b1100110; dec_tab[5] = 7'b1101101;
    dec_tab[6] = 7'b1111101; dec_tab[7] = 7'b0000111; dec_tab[8] = 7'b1111111;
    dec_tab[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b1000000;
  end

  int         k;
  int         pos;
  bit         model_valid = 1'b0;
  logic [3:0] m_sh_t, m_sh_u, m_dt, m_du;
  logic [6:0] exp_seg;
  logic [1:0] exp_an;
  logic       exp_err;

  // Reset parks the display at the first gap-after-units slot; each edge advances one slot
  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      m_sh_t = 0; m_sh_u = 0; m_dt = 0; m_du = 0;
      exp_an = 2'b11; exp_seg = 7'b0; exp_err = 1'b0;
      model_valid = 1'b1;
    end else begin
      k   = (k + 1) % PERIOD;
      pos = (2 * DIV + GAP + k) % PERIOD;
      if (pos == 0)         m_dt = m_sh_t;
      if (pos == DIV + GAP) m_du = m_sh_u;
      if (ld) begin
        m_sh_t = tens;
        m_sh_u = units;
      end
      exp_err = (m_sh_t > 9) || (m_sh_u > 9);
      exp_an  = 2'b11;
      exp_seg = 7'b0;
      if (pos < DIV) begin
        exp_an  = 2'b10;
        exp_seg = dec_tab[m_dt];
`ifdef DISP_LZB_EN
        if (m_dt == 0) begin
          exp_an  = 2'b11;
          exp_seg = 7'b0;
        end
`endif
      end else if (pos >= DIV + GAP && pos < 2 * DIV + GAP) begin
        exp_an  = 2'b01;
        exp_seg = dec_tab[m_du];
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_seg", 32'(seg), 32'(exp_seg));
      chk("model_an",  32'(an),  32'(exp_an));
      chk("model_err", 32'(err), 32'(exp_err));
    end
  end

  // Wait for the next entry into a phase whose anode pattern is tgt
  task automatic wait_entry(input logic [1:0] tgt, input string nm);
    int n;
    n = 0;
    while (an == tgt && n < 100) begin @(negedge clk); n++; end
    while (an != tgt && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL %s: timeout waiting for an=%b, an=%b", nm, tgt, an);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; ld = 1'b1; tens = 4'd5; units = 4'd5;

    // Reset dominates load
    repeat (3) begin
      @(negedge clk);
      chk("rst_an",  32'(an),  32'(2'b11));
      chk("rst_seg", 32'(seg), 32'(7'b0));
      chk("rst_err", 32'(err), 32'(1'b0));
    end
    rst = 1'b0; ld = 1'b0;
    repeat (GAP) @(negedge clk);
`ifdef DISP_LZB_EN
    chk("first_tens_an_lzb", 32'(an), 32'(2'b11));
`else
    chk("first_tens_an",  32'(an),  32'(2'b10));
    chk("first_tens_seg", 32'(seg), 32'(7'b0111111));
`endif
    repeat (DIV + GAP) @(negedge clk);
    chk("first_units_an",  32'(an),  32'(2'b01));
    chk("first_units_seg", 32'(seg), 32'(7'b0111111));

    // Full refresh pattern for 27
    ld = 1'b1; tens = 4'd2; units = 4'd7;
    @(negedge clk); ld = 1'b0;
    wait_entry(2'b10, "pat27_wait");
    for (int i = 0; i < 2 * PERIOD; i++) begin
      int p;
      p = i % PERIOD;
      if (p < DIV) begin
        chk("pat27_an", 32'(an), 32'(2'b10));
        chk("pat27_seg", 32'(seg), 32'(7'b1011011));
      end else if (p >= DIV + GAP && p < 2 * DIV + GAP) begin
        chk("pat27_an", 32'(an), 32'(2'b01));
        chk("pat27_seg", 32'(seg), 32'(7'b0000111));
      end else begin
        chk("pat27_an", 32'(an), 32'(2'b11));
        chk("pat27_seg", 32'(seg), 32'(7'b0));
      end
      @(negedge clk);
    end

    // Mid-phase load does not disturb the lit tens digit
    ld = 1'b1; tens = 4'd1; units = 4'd0;
    @(negedge clk); ld = 1'b0;
    wait_entry(2'b10, "midload_wait1");
    chk("midload_c0", 32'(seg), 32'(7'b0000110));
    @(negedge clk);
    ld = 1'b1; tens = 4'd3;
    @(negedge clk); ld = 1'b0;
    chk("midload_c2", 32'(seg), 32'(7'b0000110));
    @(negedge clk);
    chk("midload_c3", 32'(seg), 32'(7'b0000110));
    chk("midload_c3_an", 32'(an), 32'(2'b10));
    wait_entry(2'b10, "midload_wait2");
    chk("midload_next", 32'(seg), 32'(7'b1001111));

    // Out-of-range tens: error flag and dash
    ld = 1'b1; tens = 4'd12; units = 4'd4;
    @(negedge clk); ld = 1'b0;
    chk("err_set", 32'(err), 32'(1'b1));
    wait_entry(2'b10, "dash_wait");
    chk("dash_seg", 32'(seg), 32'(7'b1000000));
    ld = 1'b1; tens = 4'd1; units = 4'd4;
    @(negedge clk); ld = 1'b0;
    chk("err_clr", 32'(err), 32'(1'b0));

    // Tens zero: lit in default build, blanked with leading-zero blanking
    ld = 1'b1; tens = 4'd0; units = 4'd5;
    @(negedge clk); ld = 1'b0;
    wait_entry(2'b01, "lz_wait");
    chk("lz_units_seg", 32'(seg), 32'(7'b1101101));
    repeat (DIV + GAP) @(negedge clk);
`ifdef DISP_LZB_EN
    chk("lz_tens_an",  32'(an),  32'(2'b11));
    chk("lz_tens_seg", 32'(seg), 32'(7'b0));
`else
    chk("lz_tens_an",  32'(an),  32'(2'b10));
    chk("lz_tens_seg", 32'(seg), 32'(7'b0111111));
`endif

    // Reset in the middle of a units phase
    ld = 1'b1; tens = 4'd12; units = 4'd4;
    @(negedge clk); ld = 1'b0;
    wait_entry(2'b01, "midrst_wait");
    repeat (2) @(negedge clk);
    chk("midrst_err_before", 32'(err), 32'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an",  32'(an),  32'(2'b11));
    chk("midrst_seg", 32'(seg), 32'(7'b0));
    chk("midrst_err", 32'(err), 32'(1'b0));
    rst = 1'b0;
    repeat (GAP) @(negedge clk);
`ifdef DISP_LZB_EN
    chk("midrst_tens_an", 32'(an), 32'(2'b11));
`else
    chk("midrst_tens_an",  32'(an),  32'(2'b10));
    chk("midrst_tens_seg", 32'(seg), 32'(7'b0111111));
`endif

    // Randomized loads (mostly valid digits) with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom % 200) == 0;
      ld    = ($urandom % 4) == 0;
      tens  = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
      units = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
      @(negedge clk);
    end
    rst = 1'b0; ld = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
